// File: rtl/box_scan_ctrl_if.sv
// rtl/box_scan_ctrl_if.sv - signal bundle between box_scan_ctrl, frame RAM, box unit and host
//
// Signals:
//   start, abort, stall       host control into the sequencer
//   ram_rd, ram_addr          frame RAM read request (sequencer -> RAM)
//   ram_data                  frame RAM read data, one cycle after ram_rd
//   box_wr_en, box_value_index  box unit write port ([31:24] value, [23:0] index)
//   box_result                box unit output {xMin,xMax,yMin,yMax}
//   busy, done, result_valid, result, pixel_count  status back to the host
// Modports:
//   master  the sequencer side
//   slave   the environment side (host, RAM, box unit)
interface box_scan_ctrl_if;
    logic        start;
    logic        abort;
    logic        stall;
    logic        ram_rd;
    logic [23:0] ram_addr;
    logic [7:0]  ram_data;
    logic        box_wr_en;
    logic [31:0] box_value_index;
    logic [31:0] box_result;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic [31:0] result;
    logic [23:0] pixel_count;

    modport master (
        input  start, abort, stall, ram_data, box_result,
        output ram_rd, ram_addr, box_wr_en, box_value_index,
               busy, done, result_valid, result, pixel_count
    );

    modport slave (
        output start, abort, stall, ram_data, box_result,
        input  ram_rd, ram_addr, box_wr_en, box_value_index,
               busy, done, result_valid, result, pixel_count
    );
endinterface

// File: rtl/box_scan_ctrl.sv
// rtl/box_scan_ctrl.sv - sequencer streaming one RGB frame from frame RAM into the box unit
//
// Ports:
//   CLOCK_50  system clock
//   reset_n   asynchronous active-low reset
//   bus       box_scan_ctrl_if.master: host control/status, frame RAM read port,
//             box unit write port and result input
module box_scan_ctrl #(
    parameter int WIDTH       = 100,
    parameter int HEIGHT      = 100,
    parameter int RESET_INDEX = 99999,
    parameter int N_BYTES     = WIDTH * HEIGHT * 3
) (
    input  logic            CLOCK_50,
    input  logic            reset_n,
    box_scan_ctrl_if.master bus
);

    // An index equal to RESET_INDEX clears the box unit, so a real byte
    // address must never collide with it.
    if (N_BYTES >= RESET_INDEX) begin : g_bad_size
        $error("box_scan_ctrl: N_BYTES must be below RESET_INDEX");
    end

    localparam logic [23:0] LAST_ADDR  = 24'(N_BYTES - 1);
    localparam logic [23:0] CLEAR_IDX  = 24'(RESET_INDEX);
    localparam logic [31:0] IDLE_DRIVE = {8'hFF, 24'd0};

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH,
        CAPTURE
    } state_t;

    state_t      state;
    logic        rd_q;
    logic [23:0] addr_q;
    logic        in_pipe;

    assign in_pipe       = (state == STREAM) || (state == FLUSH);
    // Reads follow stall combinationally so a stalled cycle costs exactly one cycle.
    assign bus.ram_rd    = (state == STREAM) && !bus.stall;
    // RAM data arrives one cycle after the read; deliver it in that cycle.
    assign bus.box_wr_en = in_pipe && rd_q;
    assign bus.busy      = (state != IDLE);

    // White value with index 0 keeps the box unit untouched outside
    // the clear and delivery cycles.
    always_comb begin
        bus.box_value_index = IDLE_DRIVE;
        if (state == CLEAR) begin
            bus.box_value_index = {8'hFF, CLEAR_IDX};
        end else if (bus.box_wr_en) begin
            bus.box_value_index = {bus.ram_data, addr_q};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            rd_q             <= 1'b0;
            addr_q           <= 24'd0;
            bus.ram_addr     <= 24'd0;
            bus.done         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result       <= 32'd0;
            bus.pixel_count  <= 24'd0;
        end else begin
            bus.done <= 1'b0;
            rd_q     <= bus.ram_rd;
            addr_q   <= bus.ram_addr;

            if (bus.ram_rd) begin
                bus.ram_addr <= bus.ram_addr + 24'd1;
            end
            if (bus.box_wr_en) begin
                bus.pixel_count <= bus.pixel_count + 24'd1;
            end

            if (bus.abort && (state != IDLE)) begin
                // Any read still in flight is dropped: rd_q is cleared and
                // delivery is gated by the state anyway.
                state <= IDLE;
                rd_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            state            <= CLEAR;
                            bus.result_valid <= 1'b0;
                            bus.pixel_count  <= 24'd0;
                            bus.ram_addr     <= 24'd0;
                        end
                    end
                    CLEAR: begin
                        state <= STREAM;
                    end
                    STREAM: begin
                        if (bus.ram_rd && (bus.ram_addr == LAST_ADDR)) begin
                            state <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        state <= CAPTURE;
                    end
                    CAPTURE: begin
                        // Final byte was written at the end of FLUSH, so the
                        // box unit output already includes it here.
                        bus.result       <= bus.box_result;
                        bus.done         <= 1'b1;
                        bus.result_valid <= 1'b1;
                        state            <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_box_scan_ctrl.sv
// tb/tb_box_scan_ctrl.sv - self-checking bench for box_scan_ctrl with frame RAM and box unit models
module tb_box_scan_ctrl;

    localparam int W   = 20;
    localparam int H   = 20;
    localparam int N   = W * H * 3;
    localparam int RST = 99999;
    localparam logic [23:0] RST24 = 24'(RST);

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    box_scan_ctrl_if bus();

    box_scan_ctrl #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .RESET_INDEX(RST)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame RAM: data valid the cycle after a read.
    logic [7:0] mem [N];
    logic [7:0] rdata = 8'h00;
    always @(posedge CLOCK_50) begin
        if (bus.ram_rd && (int'(bus.ram_addr) < N)) rdata <= mem[int'(bus.ram_addr)];
        else rdata <= 8'h00;
    end
    assign bus.ram_data = rdata;

    // Box unit stand-in: index RESET_INDEX clears; dark bytes extend the box.
    // Byte i belongs to pixel i/3, x = pixel%W, y counts up from the bottom row.
    logic [7:0] bx_xmin = 8'd0, bx_xmax = 8'd0, bx_ymin = 8'd0, bx_ymax = 8'd0;
    int bx_p, bx_x, bx_y;
    always @(posedge CLOCK_50) begin
        if (bus.box_value_index[23:0] == RST24) begin
            bx_xmin <= 8'(W - 1);
            bx_xmax <= 8'd0;
            bx_ymin <= 8'(H - 1);
            bx_ymax <= 8'd0;
        end else if (bus.box_wr_en && (bus.box_value_index[31:24] < 8'h80)) begin
            bx_p = int'(bus.box_value_index[23:0]) / 3;
            bx_x = bx_p % W;
            bx_y = H - 1 - bx_p / W;
            if (8'(bx_x) < bx_xmin) bx_xmin <= 8'(bx_x);
            if (8'(bx_x) > bx_xmax) bx_xmax <= 8'(bx_x);
            if (8'(bx_y) < bx_ymin) bx_ymin <= 8'(bx_y);
            if (8'(bx_y) > bx_ymax) bx_ymax <= 8'(bx_y);
        end
    end
    assign bus.box_result = {bx_xmin, bx_xmax, bx_ymin, bx_ymax};

    // Frame-level expectation: bounding box of all dark bytes.
    function automatic logic [31:0] model_box();
        int xmn = W - 1, xmx = 0, ymn = H - 1, ymx = 0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] < 8'h80) begin
                int p = i / 3;
                int x = p % W;
                int y = H - 1 - p / W;
                if (x < xmn) xmn = x;
                if (x > xmx) xmx = x;
                if (y < ymn) ymn = y;
                if (y > ymx) ymx = y;
            end
        end
        return {8'(xmn), 8'(xmx), 8'(ymn), 8'(ymx)};
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < N; i++) mem[i] = v;
    endtask

    // Scan tracking shared between the driver and the per-cycle monitor.
    int cyc = 0;
    int exp_idx = 0, exp_rd = 0, wr_cnt = 0;
    int clr_cnt = 0, clr_cyc = -1, done_cnt = 0, done_cyc = -1;
    logic [31:0] exp_v;

    // Every cycle: reads sequential and never under stall, deliveries carry
    // the addressed byte in order, otherwise the idle drive.
    always @(negedge CLOCK_50) begin
        #2;
        if (reset_n) begin
            if (bus.ram_rd) begin
                chk("rd_addr", 32'(bus.ram_addr), 32'(exp_rd));
                chk("rd_under_stall", 32'(bus.stall), 32'd0);
                exp_rd++;
            end
            if (bus.box_wr_en) begin
                exp_v = (exp_idx < N) ? {mem[exp_idx], 24'(exp_idx)} : 32'hFFFF_FFFF;
                chk("deliver", bus.box_value_index, exp_v);
                exp_idx++;
                wr_cnt++;
            end else if (bus.box_value_index == {8'hFF, RST24}) begin
                clr_cnt++;
                clr_cyc = cyc;
            end else begin
                chk("idle_drive", bus.box_value_index, 32'hFF00_0000);
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Start is sampled at edge 0; cycle c is the interval ending at edge c.
    task automatic begin_scan();
        @(negedge CLOCK_50);
        exp_idx = 0; exp_rd = 0; wr_cnt = 0;
        clr_cnt = 0; clr_cyc = -1; done_cnt = 0; done_cyc = -1;
        cyc = 0;
        bus.start = 1'b1;
        @(posedge CLOCK_50);
    endtask

    task automatic run_scan(input int stall_at, input int busy_at,
                            input logic [31:0] lit_result, input int lit_done);
        logic [31:0] exp_res;
        int exp_done, stall_left;
        bit stalled;
        exp_res    = model_box();
        exp_done   = N + 4 + ((stall_at >= 0) ? 10 : 0);
        stall_left = 0;
        stalled    = 0;
        begin_scan();
        for (int c = 1; c <= N + 100 && done_cnt == 0; c++) begin
            @(negedge CLOCK_50);
            cyc = c;
            bus.start = (c == busy_at);
            if (stall_at >= 0 && !stalled && int'(bus.ram_addr) == stall_at) begin
                stalled = 1;
                stall_left = 10;
            end
            bus.stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
        end
        bus.stall = 1'b0;
        bus.start = 1'b0;
        @(negedge CLOCK_50);
        #3;
        chk("done_cycle_model", 32'(done_cyc), 32'(exp_done));
        chk("done_cycle_lit", 32'(done_cyc), 32'(lit_done));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("result_model", bus.result, exp_res);
        chk("result_lit", bus.result, lit_result);
        chk("result_valid", 32'(bus.result_valid), 32'd1);
        chk("pixel_count", 32'(bus.pixel_count), 32'(N));
        chk("wr_en_count", 32'(wr_cnt), 32'(N));
        chk("reads_issued", 32'(exp_rd), 32'(N));
        chk("clear_count", 32'(clr_cnt), 32'd1);
        chk("clear_cycle", 32'(clr_cyc), 32'd1);
        chk("busy_after", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ram_rd"}, 32'(bus.ram_rd), 32'd0);
        chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
        chk({tag, "_box_wr_en"}, 32'(bus.box_wr_en), 32'd0);
        chk({tag, "_box_value_index"}, bus.box_value_index, 32'hFF00_0000);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
        chk({tag, "_result"}, bus.result, 32'd0);
        chk({tag, "_pixel_count"}, 32'(bus.pixel_count), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.stall = 1'b0;
        fill(8'hFF);
        repeat (3) @(negedge CLOCK_50);
        #1;
        check_reset_values("reset");
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        // White frame: empty box stays at its cleared corners.
        run_scan(-1, -1, 32'h1300_1300, N + 4);

        // Dark first byte (x=0, y=19); start pulsed mid-scan is ignored.
        fill(8'hFF);
        mem[0] = 8'h00;
        run_scan(-1, 50, 32'h0000_1313, N + 4);

        // Dark last byte (x=19, y=0) arrives in the FLUSH cycle.
        fill(8'hFF);
        mem[N - 1] = 8'h00;
        run_scan(-1, -1, 32'h1313_0000, N + 4);

        // Two interior dark pixels (7,14) and (15,7) with a 10-cycle stall.
        fill(8'hFF);
        mem[3 * (5 * W + 7)]      = 8'h10;
        mem[3 * (12 * W + 15) + 2] = 8'h00;
        run_scan(500, -1, 32'h070F_070E, N + 14);

        // Abort in STREAM at cycle 100, then a clean scan.
        fill(8'hFF);
        begin_scan();
        for (int c = 1; c <= 150; c++) begin
            @(negedge CLOCK_50);
            cyc = c;
            bus.start = 1'b0;
            bus.abort = (c == 100);
        end
        bus.abort = 1'b0;
        #3;
        chk("abort_done_pulses", 32'(done_cnt), 32'd0);
        chk("abort_result_valid", 32'(bus.result_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ram_rd", 32'(bus.ram_rd), 32'd0);
        chk("abort_box_wr_en", 32'(bus.box_wr_en), 32'd0);
        chk("abort_pixel_count", 32'(bus.pixel_count), 32'd98);
        chk("abort_pixel_vs_wr", 32'(bus.pixel_count), 32'(wr_cnt));
        chk("abort_ram_addr", 32'(bus.ram_addr), 32'd99);
        run_scan(-1, -1, 32'h1300_1300, N + 4);

        // Reset mid-STREAM forces reset values without a clock edge.
        begin_scan();
        for (int c = 1; c <= 200; c++) begin
            @(negedge CLOCK_50);
            cyc = c;
            bus.start = 1'b0;
        end
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        #3;
        chk("post_reset_busy", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/box_scan_ctrl.md
Name: box_scan_ctrl

Overview:
Sequencer for the bounding-box unit (simpleBox). On `start`, it clears the box unit and streams one full RGB frame from frame RAM into it, one byte per cycle. It then captures the packed {xMin,xMax,yMin,yMax} result and signals completion. It sits between the frame RAM and the box unit and is the only driver of the box unit's wr_en and hex_value_index inputs.

Parameters:
WIDTH, 100, frame width in pixels
HEIGHT, 100, frame height in pixels
RESET_INDEX, 99999, index value that clears the box unit
N_BYTES, WIDTH*HEIGHT*3, bytes per frame. Elaboration error if N_BYTES >= RESET_INDEX.

Ports:
CLOCK_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to scan a frame; ignored unless IDLE
abort  in  1  cancel the scan in progress
stall  in  1  pause issuing RAM reads while high
ram_rd  out  1  frame RAM read strobe
ram_addr  out  24  frame RAM byte address
ram_data  in  8  RAM read data, valid exactly 1 cycle after ram_rd
box_wr_en  out  1  to box unit wr_en
box_value_index  out  32  to box unit: [31:24] value, [23:0] index
box_result  in  32  box unit output {xMin,xMax,yMin,yMax}
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when result is captured
result_valid  out  1  result holds a completed scan
result  out  32  captured box_result
pixel_count  out  24  bytes delivered to the box unit in the current or last scan

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - ram_rd=0, ram_addr=0, box_wr_en=0, box_value_index={8'hFF,24'd0}.
  - busy=0, done=0, result_valid=0, result=0, pixel_count=0.
  - Reset mid-scan aborts immediately. The box unit is not cleared until the next start.
- Idle drive: outside CLEAR and delivery cycles, box_value_index={8'hFF,24'd0} and box_wr_en=0.
  - Value 0xFF is white, so the box unit never updates spuriously.
  - The index is never RESET_INDEX, so the captured box state is preserved.
- FSM states: IDLE, CLEAR, STREAM, FLUSH, CAPTURE.
- IDLE:
  - start=1 and abort=0 -> CLEAR. Clears result_valid and pixel_count; ram_addr=0.
  - start=1 and abort=1 in the same cycle -> stay IDLE.
- CLEAR (exactly 1 cycle):
  - box_value_index={8'hFF,RESET_INDEX}, box_wr_en=0.
  - -> STREAM.
- STREAM:
  - ram_rd=~stall.
  - Each issued read post-increments ram_addr.
  - When the read at address N_BYTES-1 is issued -> FLUSH.
- Delivery pipeline (STREAM and FLUSH):
  - rd_q<=ram_rd; addr_q<=ram_addr.
  - In a cycle with rd_q=1: box_wr_en=1, box_value_index={ram_data,addr_q}, and pixel_count increments.
  - A read issued just before stall rises is still delivered in the following cycle.
- FLUSH (1 cycle): delivers the final byte. ram_rd=0. -> CAPTURE.
- CAPTURE (1 cycle): result<=box_result. -> IDLE.
  - On the next edge: done=1 for 1 cycle, result_valid=1 (held until the next accepted start).
- Latency with no stall:
  - start sampled at edge 0; CLEAR in cycle 1; STREAM in cycles 2..N_BYTES+1.
  - FLUSH in cycle N_BYTES+2; CAPTURE in cycle N_BYTES+3.
  - done high in cycle N_BYTES+4.
  - Each stalled STREAM cycle adds exactly 1 cycle.
- abort in CLEAR/STREAM/FLUSH/CAPTURE:
  - Next state IDLE; ram_rd=0 and box_wr_en=0 from the next cycle.
  - An in-flight read is discarded; no done pulse; result_valid stays 0.
- start while busy: ignored, no effect on the scan in progress.
- stall in CLEAR/FLUSH/CAPTURE: no effect.
- ram_addr and pixel_count are 24-bit and never exceed N_BYTES. No wrap is possible by construction.

Test Plan:
- All-0xFF frame, no stall -> done at cycle N_BYTES+4 = 30004; result=32'h6300_6300; pixel_count=30000.
- Single 0x00 byte at address 0 (pixel x=0, y=99) -> result=32'h0000_6363.
- Single 0x00 byte at address 29999 (last byte, x=99, y=0) -> result=32'h6363_0000. Proves the FLUSH byte is delivered.
- Frame as above with stall high for 10 cycles at address 5000 -> same result; done at cycle 30014; no address skipped or repeated; box_wr_en count=30000.
- abort at cycle 1000, then start -> no done for the aborted scan; second scan completes normally; CLEAR cycle observed with index 99999.
- start pulsed while busy, and reset_n low mid-STREAM -> first ignored; reset forces all outputs to reset values asynchronously and busy=0.
